icache: RTL and testbench

Direct-mapped, one-word-per-block instruction cache directly downstream of the datapath's instruction fetch port. It serves `imemREN`/`imemaddr` requests from the datapath with single-cycle hits. On a miss it issues a single-word read to the memory controller and fills the frame. Read-only: no write path, no dirty state, no flush on halt.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/icache_stats.sv | 30 +++
 rtl/icache.sv | 81 ++++++++
 tb/tb_icache.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types, including the instruction cache state and frame layout.
package cpu_types_pkg;

    localparam int ICACHE_NSETS = 16;
    // Sized for the smallest legal cache (2 sets) so every NSETS fits; narrower tags are zero-extended.
    localparam int ICACHE_TAG_W = 29;

    typedef enum logic {IDLE, FETCH} icache_state_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

endpackage

// File: rtl/icache_stats.sv
// icache_stats: hit-cycle and miss counters for the instruction cache, wrapping modulo 2^32.
module icache_stats (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        miss_start,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    logic [31:0] hit_q, hit_d, miss_q, miss_d;

    always_comb begin
        hit_d  = ihit ? hit_q + 32'd1 : hit_q;
        miss_d = miss_start ? miss_q + 32'd1 : miss_q;
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block read-only instruction cache with single-cycle hits.
// Define ICACHE_STATS_EN to add the hit_count/miss_count ports.
module icache
    import cpu_types_pkg::*;
#(
    parameter  int NSETS = ICACHE_NSETS,
    localparam int IDX_W = $clog2(NSETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    icache_state_t state_q, state_d;
    logic [29:0]   faddr_q, faddr_d;
    icache_frame_t frames_q [NSETS];
    icache_frame_t frames_d [NSETS];

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    icache_frame_t    frame;
    logic             miss_start, fill;
    logic             unused_ok;

    assign tag       = imemaddr[31:IDX_W+2];
    assign idx       = imemaddr[IDX_W+1:2];
    assign frame     = frames_q[idx];
    assign unused_ok = ^imemaddr[1:0];

    always_comb begin
        ihit       = imemREN && state_q == IDLE && frame.valid && frame.tag == ICACHE_TAG_W'(tag);
        imemload   = ihit ? frame.data : 32'h0;
        miss_start = imemREN && state_q == IDLE && !ihit;
        fill       = state_q == FETCH && !iwait;
        state_d    = state_q == IDLE ? (miss_start ? FETCH : IDLE) : (iwait ? FETCH : IDLE);
        faddr_d    = miss_start ? imemaddr[31:2] : faddr_q;
        iREN       = state_q == FETCH;
        iaddr      = iREN ? {faddr_q, 2'b00} : 32'h0;
        frames_d   = frames_q;
        if (fill)
            frames_d[faddr_q[IDX_W-1:0]] = '{valid: 1'b1, tag: ICACHE_TAG_W'(faddr_q[29:IDX_W]), data: iload};
    end

    // Only valid bits are reset; tag and data are qualified by valid.
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state_q <= IDLE;
            faddr_q <= '0;
            for (int i = 0; i < NSETS; i++)
                frames_q[i].valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            faddr_q  <= faddr_d;
            frames_q <= frames_d;
        end

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .miss_start (miss_start),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache; stimulus queues expected hits, a negedge monitor checks them.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0, checks = 0, cyc = 0, n_hit = 0, n_miss = 0;

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ihit must match the head of the queue in data and cycle; a due entry with no ihit is a miss.
    always @(negedge CLK)
        if (nRST) begin
            if (ihit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_hit: addr %h load %h (cycle %0d)", imemaddr, imemload, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (imemload !== e.data || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL hit_data: got %h at cycle %0d expected %h at cycle %0d",
                                 imemload, cyc, e.data, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_hit: got ihit=0 expected hit %h at cycle %0d", e.data, e.cyc);
            end
        end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d);
        step();
        imemREN = 1'b1;
        imemaddr = a;
        exp_q.push_back('{d, cyc});
        n_hit++;
        @(negedge CLK);
        chk("hit_iren", {31'h0, iREN}, 32'h0);
    endtask

    task automatic idle(input logic [31:0] a);
        step();
        imemREN = 1'b0;
        imemaddr = a;
        @(negedge CLK);
        chk("idle_ihit", {31'h0, ihit}, 32'h0);
        chk("idle_iren", {31'h0, iREN}, 32'h0);
        chk("idle_load", imemload, 32'h0);
    endtask

    // FETCH phase for a latched address a, while imemaddr shows alt; ends with the cycle after the fill.
    task automatic fetch(input logic [31:0] a, input logic [31:0] alt, input logic [31:0] d, input int nw);
        for (int i = 0; i <= nw; i++) begin
            step();
            imemaddr = alt;
            iwait = (i < nw);
            iload = (i < nw) ? 32'hBAD0_0000 : d;
            @(negedge CLK);
            chk("fetch_iren", {31'h0, iREN}, 32'h1);
            chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
            chk("fetch_ihit", {31'h0, ihit}, 32'h0);
        end
        step();
        iwait = 1'b1;
        iload = 32'h0;
        if (alt == a) begin
            exp_q.push_back('{d, cyc});
            n_hit++;
        end
        @(negedge CLK);
        chk("post_fill_iren", {31'h0, iREN}, 32'h0);
    endtask

    task automatic request_miss(input logic [31:0] a);
        step();
        imemREN = 1'b1;
        imemaddr = a;
        n_miss++;
        @(negedge CLK);
        chk("miss_ihit", {31'h0, ihit}, 32'h0);
        chk("miss_load", imemload, 32'h0);
        chk("miss_iren", {31'h0, iREN}, 32'h0);
    endtask

    task automatic miss(input logic [31:0] a, input logic [31:0] d, input int nw);
        request_miss(a);
        fetch(a, a, d, nw);
    endtask

    initial begin
        imemaddr = 32'h40;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_load", imemload, 32'h0);
        chk("rst_iren", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        step();
        nRST = 1'b1;

        miss(32'h40, 32'h2001_0005, 3);
        hit(32'h40, 32'h2001_0005);
        idle(32'h40);
        miss(32'h80, 32'hDEAD_BEEF, 0);
        hit(32'h80, 32'hDEAD_BEEF);
        miss(32'h40, 32'h2001_0005, 1);

        request_miss(32'h100);
        fetch(32'h100, 32'h104, 32'hA0A0_0100, 1);
        n_miss++;
        fetch(32'h104, 32'h104, 32'hB0B0_0104, 0);
        hit(32'h100, 32'hA0A0_0100);
        idle(32'h0);

        request_miss(32'h108);
        step();
        iwait = 1'b1;
        @(negedge CLK);
        chk("pre_rst_iren", {31'h0, iREN}, 32'h1);
        #1 nRST = 1'b0;
        #1;
        chk("async_rst_iren", {31'h0, iREN}, 32'h0);
        chk("async_rst_iaddr", iaddr, 32'h0);
        n_hit = 0;
        n_miss = 0;
        imemREN = 1'b0;
        step();
        step();
        nRST = 1'b1;

        miss(32'h100, 32'h1111_2222, 0);
        miss(32'h44, 32'h3333_4444, 2);
        hit(32'h100, 32'h1111_2222);
        idle(32'h100);
`ifdef ICACHE_STATS_EN
        chk("miss_count", miss_count, n_miss);
        chk("hit_count", hit_count, n_hit);
        chk("miss_count_2", miss_count, 32'd2);
        chk("hit_count_3", hit_count, 32'd3);
`endif
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_hits: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
